// File: rtl/combi_hazard_ctrl_if.sv
// Hazard-controller bus: D/E/M/W pipeline status in, stall/flush/forward/trap controls out.
// The core side uses master, the controller uses slave.
interface combi_hazard_ctrl_if;
   logic       armD;
   logic       instrValidD;
   logic [4:0] Rs1D, Rs2D;
   logic [4:0] Rs1E, Rs2E;
   logic [4:0] RdE, RdM, RdW;
   logic       armE;
   logic       ResultSrcE0;
   logic       RegWriteM;
   logic       RegWriteW;
   logic       PCSrcE;
   logic       trapAck;
   logic       armIn;
   logic       wasNotFlushed;
   logic       StallF, StallD;
   logic       FlushD, FlushE;
   logic [1:0] ForwardAE, ForwardBE;
   logic       Trap, TrapArm;

   modport master (
      output armD, instrValidD, Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
             armE, ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, trapAck,
      input  armIn, wasNotFlushed, StallF, StallD, FlushD, FlushE,
             ForwardAE, ForwardBE, Trap, TrapArm
   );

   modport slave (
      input  armD, instrValidD, Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
             armE, ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, trapAck,
      output armIn, wasNotFlushed, StallF, StallD, FlushD, FlushE,
             ForwardAE, ForwardBE, Trap, TrapArm
   );
endinterface

// File: rtl/combi_hazard_ctrl.sv
// Pipeline controller for the combined ARM/RISC-V 5-stage core: ISA-mode and D-validity
// ownership, load-use stalls, redirect flushes, E-stage forwarding and illegal-instruction trap.
module combi_hazard_ctrl #(
   parameter bit RESET_ARM     = 1'b0,
   parameter int ILLEGAL_LIMIT = 2
) (
   input logic                clk,
   input logic                reset,
   combi_hazard_ctrl_if.slave hz
);

   typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_e;

   localparam logic [4:0] LIMIT = 5'(ILLEGAL_LIMIT);

   state_e     state_q, state_d;
   logic       armIn_q, armIn_d;
   logic       wnf_q, wnf_d;
   logic       trapArm_q, trapArm_d;
   logic [3:0] cnt_q, cnt_d;

   logic lwStall, illegal, enterTrap, updMode;
   logic stallF, stallD, flushD, flushE;

   // ARM r0 is a real register; PC (r15) is never forwarded
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic armE,
                                          input logic rwM, input logic [4:0] rdM,
                                          input logic rwW, input logic [4:0] rdW);
      logic ok;
      ok = armE ? (rs != 5'd15) : (rs != 5'd0);
      if (rwM && (rdM == rs) && ok)      return 2'b10;
      else if (rwW && (rdW == rs) && ok) return 2'b01;
      else                               return 2'b00;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   always_comb begin
      lwStall = (state_q == RUN) & hz.ResultSrcE0 & wnf_q &
                (hz.armE | (hz.RdE != 5'd0)) &
                ((hz.RdE == hz.Rs1D) | (hz.RdE == hz.Rs2D));
      illegal   = (state_q == RUN) & wnf_q & ~hz.instrValidD & ~stallD & ~hz.PCSrcE;
      enterTrap = illegal & (({1'b0, cnt_q} + 5'd1) >= LIMIT);
      state_d   = state_q;
      case (state_q)
         RUN:     if (enterTrap)  state_d = TRAP;
         TRAP:    if (hz.trapAck) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // Redirect wins over load-use: flush without stalling
   always_comb begin
      stallF = 1'b0;
      stallD = 1'b0;
      flushD = 1'b0;
      flushE = 1'b0;
      case (state_q)
         RUN: begin
            stallF = lwStall & ~hz.PCSrcE;
            stallD = lwStall & ~hz.PCSrcE;
            flushD = hz.PCSrcE;
            flushE = lwStall | hz.PCSrcE;
         end
         TRAP: begin
            stallF = 1'b1;
            flushD = 1'b1;
            flushE = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      updMode   = wnf_q & hz.instrValidD & ~stallD & ~flushD & (state_q == RUN);
      armIn_d   = updMode ? hz.armD : armIn_q;
      wnf_d     = flushD ? 1'b0 : (stallD ? wnf_q : 1'b1);
      trapArm_d = enterTrap ? armIn_q : trapArm_q;
      cnt_d     = cnt_q;
      if (enterTrap || hz.PCSrcE || (wnf_q && hz.instrValidD)) cnt_d = 4'd0;
      else if (illegal && (cnt_q != 4'hF))                      cnt_d = cnt_q + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         armIn_q   <= RESET_ARM;
         wnf_q     <= 1'b0;
         trapArm_q <= 1'b0;
         cnt_q     <= 4'd0;
      end else begin
         armIn_q   <= armIn_d;
         wnf_q     <= wnf_d;
         trapArm_q <= trapArm_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      hz.armIn         = armIn_q;
      hz.wasNotFlushed = wnf_q;
      hz.StallF        = stallF;
      hz.StallD        = stallD;
      hz.FlushD        = flushD;
      hz.FlushE        = flushE;
      hz.Trap          = (state_q == TRAP);
      hz.TrapArm       = trapArm_q;
      hz.ForwardAE     = fwd_sel(hz.Rs1E, hz.armE, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
      hz.ForwardBE     = fwd_sel(hz.Rs2E, hz.armE, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
   end

endmodule

// File: tb/tb_combi_hazard_ctrl.sv
// Scoreboard bench for combi_hazard_ctrl: directed hazard/trap scenarios followed by
// randomized traffic, all predicted by a behavioural model of the controller.
module tb_combi_hazard_ctrl;
   localparam bit RESET_ARM = 1'b1;
   localparam int LIMIT     = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   combi_hazard_ctrl_if bus();

   combi_hazard_ctrl #(.RESET_ARM(RESET_ARM), .ILLEGAL_LIMIT(LIMIT)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (bus)
   );

   typedef struct packed {
      logic       reset, armD, valid;
      logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
      logic       armE, resSrc, rwM, rwW, pcsrc, ack;
   } stim_t;

   typedef struct packed {
      logic       armIn, wnf, stallF, stallD, flushD, flushE;
      logic [1:0] fwdA, fwdB;
      logic       trap, trapArm;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   bit   m_arm, m_wnf, m_trap, m_trapArm;
   int   m_cnt;

   task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s cycle=%0d got=%0b expected=%0b", nm, cyc, act, want);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (sb.size() != 0) begin
         mon_e = sb.pop_front();
         chk("armIn",         {1'b0, bus.armIn},         {1'b0, mon_e.armIn});
         chk("wasNotFlushed", {1'b0, bus.wasNotFlushed}, {1'b0, mon_e.wnf});
         chk("StallF",        {1'b0, bus.StallF},        {1'b0, mon_e.stallF});
         chk("StallD",        {1'b0, bus.StallD},        {1'b0, mon_e.stallD});
         chk("FlushD",        {1'b0, bus.FlushD},        {1'b0, mon_e.flushD});
         chk("FlushE",        {1'b0, bus.FlushE},        {1'b0, mon_e.flushE});
         chk("ForwardAE",     bus.ForwardAE,             mon_e.fwdA);
         chk("ForwardBE",     bus.ForwardBE,             mon_e.fwdB);
         chk("Trap",          {1'b0, bus.Trap},          {1'b0, mon_e.trap});
         chk("TrapArm",       {1'b0, bus.TrapArm},       {1'b0, mon_e.trapArm});
      end
   end

   function automatic logic [1:0] fwd(input logic [4:0] rs, input logic armE,
                                      input logic rwM, input logic [4:0] rdM,
                                      input logic rwW, input logic [4:0] rdW);
      bit usable;
      usable = armE ? (rs != 5'd15) : (rs != 5'd0);
      if (!usable)                return 2'b00;
      if (rwM && rdM == rs)       return 2'b10;
      if (rwW && rdW == rs)       return 2'b01;
      return 2'b00;
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      s.valid = 1'b1;
      s.Rs1D = 5'd1;  s.Rs2D = 5'd2;
      s.Rs1E = 5'd6;  s.Rs2E = 5'd7;
      s.RdE  = 5'd8;  s.RdM  = 5'd9;  s.RdW = 5'd10;
      return s;
   endfunction

   function automatic logic [4:0] rreg();
      int r;
      r = $urandom_range(0, 5);
      if (r == 5) return 5'd15;
      return 5'(r);
   endfunction

   function automatic stim_t rnd();
      stim_t s;
      s.reset  = ($urandom_range(0, 149) == 0);
      s.armD   = 1'($urandom_range(0, 1));
      s.valid  = ($urandom_range(0, 9) < 7);
      s.Rs1D   = rreg(); s.Rs2D = rreg();
      s.Rs1E   = rreg(); s.Rs2E = rreg();
      s.RdE    = rreg(); s.RdM  = rreg(); s.RdW = rreg();
      s.armE   = 1'($urandom_range(0, 1));
      s.resSrc = ($urandom_range(0, 2) == 0);
      s.rwM    = 1'($urandom_range(0, 1));
      s.rwW    = 1'($urandom_range(0, 1));
      s.pcsrc  = ($urandom_range(0, 9) == 0);
      s.ack    = ($urandom_range(0, 3) == 0);
      return s;
   endfunction

   task automatic drive(input stim_t s);
      reset           = s.reset;
      bus.armD        = s.armD;
      bus.instrValidD = s.valid;
      bus.Rs1D        = s.Rs1D;
      bus.Rs2D        = s.Rs2D;
      bus.Rs1E        = s.Rs1E;
      bus.Rs2E        = s.Rs2E;
      bus.RdE         = s.RdE;
      bus.RdM         = s.RdM;
      bus.RdW         = s.RdW;
      bus.armE        = s.armE;
      bus.ResultSrcE0 = s.resSrc;
      bus.RegWriteM   = s.rwM;
      bus.RegWriteW   = s.rwW;
      bus.PCSrcE      = s.pcsrc;
      bus.trapAck     = s.ack;
   endtask

   task automatic model_reset();
      m_arm = RESET_ARM; m_wnf = 1'b0; m_trap = 1'b0; m_trapArm = 1'b0; m_cnt = 0;
   endtask

   // Drive one cycle, predict this cycle's outputs, then advance the model past the edge
   task automatic step(input stim_t s);
      exp_t e;
      bit   run, lw, ill, enter;
      drive(s);
      run = !m_trap;
      lw  = run && s.resSrc && m_wnf && (s.armE || s.RdE != 5'd0) &&
            (s.RdE == s.Rs1D || s.RdE == s.Rs2D);
      if (run) begin
         e.stallF = lw && !s.pcsrc;
         e.stallD = lw && !s.pcsrc;
         e.flushD = s.pcsrc;
         e.flushE = lw || s.pcsrc;
      end else begin
         e.stallF = 1'b1; e.stallD = 1'b0; e.flushD = 1'b1; e.flushE = 1'b1;
      end
      e.armIn   = m_arm;
      e.wnf     = m_wnf;
      e.trap    = m_trap;
      e.trapArm = m_trapArm;
      e.fwdA    = fwd(s.Rs1E, s.armE, s.rwM, s.RdM, s.rwW, s.RdW);
      e.fwdB    = fwd(s.Rs2E, s.armE, s.rwM, s.RdM, s.rwW, s.RdW);
      sb.push_back(e);

      if (s.reset) begin
         model_reset();
      end else begin
         ill   = run && m_wnf && !s.valid && !e.stallD && !s.pcsrc;
         enter = ill && (m_cnt + 1 >= LIMIT);
         if (enter) m_trapArm = m_arm;
         if (run && m_wnf && s.valid && !e.stallD && !e.flushD) m_arm = s.armD;
         if (!run || enter || s.pcsrc || (m_wnf && s.valid)) m_cnt = 0;
         else if (ill && m_cnt < 15) m_cnt = m_cnt + 1;
         m_trap = run ? enter : !s.ack;
         if (e.flushD)      m_wnf = 1'b0;
         else if (!e.stallD) m_wnf = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      stim_t s;
      s = idle();
      s.reset = 1'b1;
      drive(s);
      @(posedge clk);
      #1;
      model_reset();

      // load-use with RdE=5, then RdE=0 (RISC-V x0 never stalls)
      s = idle(); step(s); step(s);
      s.resSrc = 1'b1; s.RdE = 5'd5; s.Rs1D = 5'd5; step(s);
      s.RdE = 5'd0; s.Rs1D = 5'd0; step(s);
      s.armE = 1'b1; step(s);

      // redirect coinciding with load-use
      s = idle(); s.resSrc = 1'b1; s.RdE = 5'd5; s.Rs1D = 5'd5; s.pcsrc = 1'b1; step(s);
      s = idle(); step(s); step(s);

      // mode switch: stalled instruction must not change mode, unstalled one does
      s = idle(); s.armD = 1'b0; step(s); step(s);
      s.armD = 1'b1; s.resSrc = 1'b1; s.RdE = 5'd4; s.Rs2D = 5'd4; step(s); step(s);
      s = idle(); s.armD = 1'b1; step(s); step(s);

      // forwarding corner cases
      s = idle(); s.rwM = 1'b1; s.rwW = 1'b1; s.RdM = 5'd3; s.RdW = 5'd3; s.Rs1E = 5'd3; step(s);
      s.RdM = 5'd0; s.RdW = 5'd0; s.Rs1E = 5'd0; step(s);
      s.armE = 1'b1; step(s);
      s.RdM = 5'd15; s.RdW = 5'd15; s.Rs1E = 5'd15; s.Rs2E = 5'd15; step(s);
      s.armE = 1'b0; s.RdM = 5'd2; s.Rs2E = 5'd2; s.RdW = 5'd4; s.Rs1E = 5'd4; step(s);
      s.rwM = 1'b0; step(s);

      // illegal-instruction trap in ARM mode, held, then acknowledged
      s = idle(); s.armD = 1'b1; step(s); step(s);
      s.valid = 1'b0; step(s); step(s);
      s = idle(); s.pcsrc = 1'b1; repeat (5) step(s);
      s.pcsrc = 1'b0; s.ack = 1'b1; step(s);
      s.ack = 1'b0; step(s); step(s);

      // reset while trapped
      s.valid = 1'b0; step(s); step(s);
      s.valid = 1'b1; step(s);
      s.reset = 1'b1; step(s);
      s.reset = 1'b0; step(s); step(s);

      for (int i = 0; i < 3000; i++) step(rnd());

      @(negedge clk);
      #1;
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain leftover=%0d expected=0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
